// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: RV32M funct3
// encodings, controller states and two's-complement helpers.
package muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Operates at the widest legal XLEN; callers zero-extend in and truncate
    // out, which is exact because negation is modular.
    function automatic logic [63:0] md_neg(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    function automatic logic [63:0] md_abs(input logic [63:0] v, input logic is_neg);
        return is_neg ? md_neg(v) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. One operand bit per cycle using a
// shared 2*XLEN shift register and an XLEN+1-bit adder/subtractor.
//
// state   | meaning
// --------+-----------------------------------------------------------
// MD_IDLE | waiting for a request
// MD_CALC | iterating, one bit per cycle, counter counts XLEN..1
// MD_DONE | result cycle; special-case result is emitted on leaving
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic            i_flush,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN + 1);

    md_state_e         state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic              neg_q;
    logic              spec_q;
    logic [XLEN-1:0]   opb_q;
    logic [2*XLEN-1:0] acc_q;

    logic              accept;
    logic              m1_neg, m2_neg, res_neg;
    logic [XLEN-1:0]   mag1, mag2;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   spec_res;

    logic              is_mul;
    logic [XLEN:0]     add_a, add_b, sum;
    logic [2*XLEN-1:0] acc_nxt;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   div_sel;
    logic [XLEN-1:0]   fin_res;

    assign o_ready = (state == MD_IDLE) || (state == MD_DONE);
    assign accept  = i_valid && o_ready && !i_flush;

    // Request decode: operand sign handling and divide special cases.
    always_comb begin
        m1_neg  = 1'b0;
        m2_neg  = 1'b0;
        res_neg = 1'b0;
        case (i_op)
            MD_MULH, MD_DIV: begin
                m1_neg  = i_op1[XLEN-1];
                m2_neg  = i_op2[XLEN-1];
                res_neg = i_op1[XLEN-1] ^ i_op2[XLEN-1];
            end
            MD_MULHSU: begin
                m1_neg  = i_op1[XLEN-1];
                res_neg = i_op1[XLEN-1];
            end
            MD_REM: begin
                m1_neg  = i_op1[XLEN-1];
                m2_neg  = i_op2[XLEN-1];
                res_neg = i_op1[XLEN-1];
            end
            default: ;
        endcase
        mag1     = XLEN'(md_abs(64'(i_op1), m1_neg));
        mag2     = XLEN'(md_abs(64'(i_op2), m2_neg));
        div_zero = i_op[2] && (i_op2 == '0);
        div_ovf  = ((i_op == MD_DIV) || (i_op == MD_REM)) &&
                   (i_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_op2 == '1);
        special  = div_zero || div_ovf;
        if (div_zero)
            spec_res = i_op[1] ? i_op1 : '1;
        else
            spec_res = i_op[1] ? '0 : i_op1;
    end

    // One iteration of shift-add (multiply) or restoring subtract (divide),
    // plus the sign-corrected result taken from the final iteration.
    always_comb begin
        is_mul = ~op_q[2];
        add_a  = is_mul ? {1'b0, acc_q[2*XLEN-1:XLEN]} : {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        add_b  = is_mul ? {1'b0, opb_q} : ~{1'b0, opb_q};
        sum    = add_a + add_b + {{XLEN{1'b0}}, ~is_mul};
        if (is_mul)
            acc_nxt = acc_q[0] ? {sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
        else
            acc_nxt = !sum[XLEN] ? {sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                                 : {acc_q[2*XLEN-2:0], 1'b0};
        prod    = neg_q ? (~acc_nxt + (2*XLEN)'(1)) : acc_nxt;
        div_sel = op_q[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
        if (is_mul)
            fin_res = (op_q == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else
            fin_res = neg_q ? XLEN'(md_neg(64'(div_sel))) : div_sel;
    end

    // Controller FSM, datapath registers and registered result/valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= MD_IDLE;
            cnt      <= '0;
            op_q     <= MD_MUL;
            neg_q    <= 1'b0;
            spec_q   <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            o_valid  <= 1'b0;
            o_result <= '0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                MD_IDLE: ;
                MD_CALC: begin
                    if (i_flush) begin
                        state <= MD_IDLE;
                    end else begin
                        acc_q <= acc_nxt;
                        cnt   <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            o_result <= fin_res;
                            o_valid  <= 1'b1;
                            state    <= MD_DONE;
                        end
                    end
                end
                MD_DONE: begin
                    // A special-case result was parked in acc_q on accept.
                    if (!i_flush && spec_q) begin
                        o_result <= acc_q[XLEN-1:0];
                        o_valid  <= 1'b1;
                    end
                    state  <= MD_IDLE;
                    spec_q <= 1'b0;
                end
                default: state <= MD_IDLE;
            endcase
            if (accept) begin
                op_q   <= i_op;
                neg_q  <= res_neg;
                spec_q <= special;
                cnt    <= CW'(XLEN);
                opb_q  <= i_op[2] ? mag2 : mag1;
                acc_q  <= special ? {{XLEN{1'b0}}, spec_res}
                                  : {{XLEN{1'b0}}, (i_op[2] ? mag1 : mag2)};
                state  <= special ? MD_DONE : MD_CALC;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: requests push expected result and due
// cycle; a monitor pops and compares on every o_valid pulse.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN = 32;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_valid;
    logic            o_ready;
    logic [2:0]      i_op;
    logic [XLEN-1:0] i_op1;
    logic [XLEN-1:0] i_op2;
    logic            i_flush;
    logic            o_valid;
    logic [XLEN-1:0] o_result;

    typedef struct {
        logic [31:0] res;
        int          due;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   errors     = 0;
    int   checks     = 0;
    int   cyc        = 0;
    int   last_valid = 0;
    int   prev_valid = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_op1    (i_op1),
        .i_op2    (i_op2),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .o_result (o_result)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: compare every result pulse against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(posedge i_clk);
            cyc++;
            #1;
            if (o_valid === 1'b1) begin
                prev_valid = last_valid;
                last_valid = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: pulse at cycle %0d result %h, expected none", cyc, o_result);
                end else begin
                    e = exp_q.pop_front();
                    check(e.name, o_result, e.res);
                    check({e.name, "_latency"}, 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] res, input string name);
        int n = 0;
        exp_t e;
        @(negedge i_clk);
        while (o_ready !== 1'b1 && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (o_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_ready: o_ready stayed %b, expected 1", name, o_ready);
            return;
        end
        i_valid = 1'b1;
        i_op    = op;
        i_op1   = a;
        i_op2   = b;
        @(posedge i_clk);
        #1;
        e.res  = res;
        e.due  = cyc + lat;
        e.name = name;
        exp_q.push_back(e);
        i_valid = 1'b0;
        i_op1   = $urandom;
        i_op2   = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_op    = MD_MUL;
        i_op1   = '0;
        i_op2   = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("reset_ready",  32'(o_ready), 32'd1);
        check("reset_valid",  32'(o_valid), 32'd0);
        check("reset_result", o_result,     32'd0);
        i_rst = 1'b0;

        issue(MD_MUL,    32'd7,        32'hFFFFFFFD, 32, 32'hFFFFFFEB, "mul_7_m3");
        issue(MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'hFFFFFFFE, "mulhu_max");
        issue(MD_MULH,   32'h80000000, 32'h80000000, 32, 32'h40000000, "mulh_min");
        issue(MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'hFFFFFFFF, "mulhsu_m1");
        issue(MD_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'h00000000, "mulh_m1_m1");
        issue(MD_DIV,    32'hFFFFFFF9, 32'd2,        32, 32'hFFFFFFFD, "div_m7_2");
        issue(MD_REM,    32'hFFFFFFF9, 32'd2,        32, 32'hFFFFFFFF, "rem_m7_2");
        issue(MD_DIVU,   32'd100,      32'd7,        32, 32'd14,       "divu_100_7");
        issue(MD_DIVU,   32'h00001234, 32'd0,        1,  32'hFFFFFFFF, "divu_by0");
        issue(MD_REMU,   32'h00001234, 32'd0,        1,  32'h00001234, "remu_by0");
        issue(MD_DIV,    32'h80000000, 32'hFFFFFFFF, 1,  32'h80000000, "div_ovf");
        issue(MD_REM,    32'h80000000, 32'hFFFFFFFF, 1,  32'h00000000, "rem_ovf");
        issue(MD_REM,    32'hFFFFFFFB, 32'd0,        1,  32'hFFFFFFFB, "rem_by0_neg");
        issue(MD_DIVU,   32'h80000000, 32'hFFFFFFFF, 32, 32'h00000000, "divu_no_ovf");
        issue(MD_REMU,   32'd100,      32'd7,        32, 32'd2,        "remu_100_7");
        drain();

        // Flush in the 10th CALC cycle: no result, ready next cycle, result kept.
        issue(MD_MUL, 32'd7, 32'd3, 32, 32'd21, "flushed_mul");
        repeat (10) @(negedge i_clk);
        i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        void'(exp_q.pop_back());
        check("flush_ready",  32'(o_ready), 32'd1);
        check("flush_valid",  32'(o_valid), 32'd0);
        check("flush_result", o_result,     32'd2);
        repeat (40) @(negedge i_clk);

        // Flush together with a request in IDLE rejects it.
        @(negedge i_clk);
        i_valid = 1'b1;
        i_flush = 1'b1;
        i_op    = MD_DIVU;
        i_op1   = 32'h00001234;
        i_op2   = 32'd0;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_flush = 1'b0;
        check("flush_reject_ready", 32'(o_ready), 32'd1);
        repeat (10) @(negedge i_clk);
        check("flush_reject_result", o_result, 32'd2);

        // Reset mid-CALC.
        issue(MD_MUL, 32'd5, 32'd6, 32, 32'd30, "reset_mul");
        repeat (5) @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        void'(exp_q.pop_back());
        check("midreset_ready",  32'(o_ready), 32'd1);
        check("midreset_valid",  32'(o_valid), 32'd0);
        check("midreset_result", o_result,     32'd0);
        repeat (40) @(negedge i_clk);

        // Back-to-back: second request accepted in DONE of the first.
        issue(MD_MUL, 32'h12345678, 32'h00000010, 32, 32'h23456780, "b2b_first");
        issue(MD_DIV, 32'hFFFFFFF9, 32'd2,        32, 32'hFFFFFFFD, "b2b_second");
        drain();
        check("b2b_spacing", 32'(last_valid - prev_valid), 32'd33);

        repeat (5) @(negedge i_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for an XLEN-wide datapath. It sits beside the combinational ALU in the execute stage. A valid/ready handshake starts an operation; the unit then processes one operand bit per cycle and returns the result as a single-cycle `o_valid` pulse. A flush input kills an in-flight operation when the pipeline is redirected.

## Interface
- `XLEN`, default 32: operand/result width. Legal values are 8..64, power of two.
- `i_clk`  in  1: clock; all state updates on the rising edge.
- `i_rst`  in  1: reset, synchronous, active-high.
- `i_valid`  in  1: request valid; operands and op are sampled on accept.
- `o_ready`  out  1: unit can accept a request this cycle.
- `i_op`  in  3: RV32M funct3. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `i_op1`  in  XLEN: rs1 operand (multiplicand/dividend).
- `i_op2`  in  XLEN: rs2 operand (multiplier/divisor).
- `i_flush`  in  1: abort any in-flight operation; no result is produced for it.
- `o_valid`  out  1: one-cycle pulse; `o_result` is valid in that cycle.
- `o_result`  out  XLEN: result; held stable until the next completion.

## Operation
- States: IDLE, CALC, DONE.
- Accept: `i_valid && o_ready && !i_flush` at a rising edge. On accept the unit latches op, operand magnitudes, sign-fix flags and the special-case flags.
- Transitions:
  - IDLE -> CALC on a normal accept.
  - IDLE -> DONE on a special-case accept.
  - CALC -> DONE when the bit counter expires.
  - DONE -> IDLE when there is no accept.
  - DONE -> CALC or DONE when a new request is accepted in DONE (back-to-back).
- `o_ready` = (state == IDLE) || (state == DONE).
- Multiply:
  - Shift-add on unsigned magnitudes into a 2·XLEN product.
  - Negate the product if the effective signs differ. MULH: both operands signed. MULHSU: op1 signed, op2 unsigned. MULHU and MUL: unsigned magnitudes.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide:
  - Restoring division on magnitudes for DIV/REM; raw operands for DIVU/REMU.
  - Quotient is negated if the signs differ (DIV). Remainder takes the sign of the dividend (REM).
- Special cases (no iteration):
  - Divisor zero: quotient = all ones; remainder = op1.
  - Signed overflow (op1 = most negative value, op2 = −1, DIV/REM): quotient = op1; remainder = 0.
- All arithmetic is modulo 2^XLEN on the output; no exceptions or flags are raised.
- Flush:
  - In CALC or DONE, go to IDLE next edge. `o_valid` stays low, or is forced low if in DONE. `o_result` is unchanged.
  - A flush in the same cycle as `i_valid` rejects the request.
- Reset: state = IDLE, `o_valid` = 0, `o_result` = 0, counter = 0. `o_ready` = 1 in the first cycle after reset. Reset mid-operation discards the operation and produces no `o_valid`.

## Timing
- The accept edge is E0.
- Normal operation:
  - CALC occupies edges E1..E(XLEN).
  - `o_valid` rises after edge E(XLEN), so latency is XLEN cycles.
- Special cases: `o_valid` after E1, so latency is 1 cycle.
- `o_valid` is registered and is high for exactly one cycle per accepted, unflushed request.
- Back-to-back: an accept in DONE gives a throughput of one result per XLEN+1 cycles.
- Operand inputs may change freely after E0.
- Counter width is $clog2(XLEN+1). It is loaded with XLEN on accept and decremented each CALC cycle; the CALC -> DONE transition occurs when the counter reaches 1.

## Structure
- Package `muldiv_pkg`:
  - op encoding localparams (`MD_MUL`..`MD_REMU`);
  - state enum (`MD_IDLE`, `MD_CALC`, `MD_DONE`);
  - helper function for two's-complement negate/abs of XLEN-wide values.
- Single module. Multiply and divide share one 2·XLEN shift register and one XLEN+1-bit adder/subtractor, so no sub-module is warranted.

## Test plan
- **Multiply, XLEN=32:** MUL 7 × 0xFFFFFFFD -> 0xFFFFFFEB, with `o_valid` exactly 32 cycles after accept. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- **Signed high multiply:** MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- **Signed divide:** DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU -> 2.
- **Special cases, latency 1:** DIVU 0x1234 / 0 -> 0xFFFFFFFF. REMU -> 0x1234. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM -> 0.
- **Flush:** assert `i_flush` in the 10th CALC cycle -> no `o_valid`, `o_ready` = 1 the next cycle, `o_result` keeps its previous value. Also assert `i_flush` together with `i_valid` in IDLE -> request is not accepted.
- **Reset and back-to-back:** assert `i_rst` mid-CALC -> next cycle `o_ready` = 1, `o_valid` = 0, `o_result` = 0. Issue two back-to-back requests accepted in DONE -> two `o_valid` pulses 33 cycles apart with correct results.
